// File: rtl/spike_rate_counter.sv
// Windowed spike-rate counter for the neuron's spike output.
// Counts rising edges per window and hands each count to a valid/ready port.
module spike_rate_counter #(
  parameter int CNT_W = 8,
  parameter int WIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic             spike_in,
  input  logic             rate_ready,
  output logic [CNT_W-1:0] rate_data,
  output logic             rate_sat,
  output logic             rate_valid,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  state_t           state;
  state_t           state_nx;
  logic             spike_d;
  logic [WIN_W-1:0] win_reg;
  logic [WIN_W-1:0] cyc;
  logic [CNT_W-1:0] cnt;
  logic             sat_flag;

  logic             rise;
  logic             at_max;
  logic             sat_hit;
  logic [CNT_W-1:0] cnt_inc;
  logic             start_ok;
  logic             last;
  logic             can_load;
  logic             load;
  logic             drop;
  logic             relatch;

  always_comb begin
    rise     = spike_in & ~spike_d;
    at_max   = (cnt == CNT_MAX);
    sat_hit  = rise & at_max;
    cnt_inc  = (rise && !at_max) ? cnt + CNT_ONE : cnt;
    start_ok = en && (win_len != '0);
    last     = (state == RUN) && (cyc == win_reg - WIN_ONE);
    can_load = !rate_valid || rate_ready;
    load     = last && can_load;
    drop     = last && !can_load;
    // A new window begins either from IDLE or straight off a finished one.
    relatch  = start_ok && ((state == IDLE) || last);
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nx = RUN;
      end
      RUN: begin
        if (last)     state_nx = start_ok ? RUN : IDLE;
        else if (!en) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_d    <= 1'b0;
      win_reg    <= '0;
      cyc        <= '0;
      cnt        <= '0;
      sat_flag   <= 1'b0;
      rate_data  <= '0;
      rate_sat   <= 1'b0;
      rate_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      spike_d <= spike_in;

      if (relatch) begin
        win_reg  <= win_len;
        cyc      <= '0;
        cnt      <= '0;
        sat_flag <= 1'b0;
      end else if (state == RUN) begin
        cyc      <= cyc + WIN_ONE;
        cnt      <= cnt_inc;
        sat_flag <= sat_flag | sat_hit;
      end

      if (load) begin
        rate_data  <= cnt_inc;
        rate_sat   <= sat_flag | sat_hit;
        rate_valid <= 1'b1;
      end else if (rate_valid && rate_ready) begin
        rate_valid <= 1'b0;
      end

      if (drop)             overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_spike_rate_counter.sv
// Bench for spike_rate_counter: vector table, directed corner
// sequences and a random run against a window-level reference model.
module tb_spike_rate_counter;

  localparam int MAX = 255;

  logic       clk = 1'b0;
  logic       rst, en, spike_in, rate_ready, overrun_clr;
  logic [7:0] win_len;
  logic [7:0] rate_data;
  logic       rate_sat, rate_valid, overrun, busy;

  logic       rst4, en4, sp4, rdy4, clr4;
  logic [7:0] wl4;
  logic [3:0] data4;
  logic       sat4, valid4, ovr4, busy4;

  int vectors = 0;
  int miscompares = 0;

  bit m_run, m_prev, m_valid, m_sat, m_ovr;
  int m_left, m_edges, m_data;

  always #5 clk = ~clk;

  spike_rate_counter #(.CNT_W(8), .WIN_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .win_len(win_len),
    .spike_in(spike_in), .rate_ready(rate_ready),
    .rate_data(rate_data), .rate_sat(rate_sat),
    .rate_valid(rate_valid), .overrun(overrun),
    .overrun_clr(overrun_clr), .busy(busy)
  );

  spike_rate_counter #(.CNT_W(4), .WIN_W(8)) u4 (
    .clk(clk), .rst(rst4), .en(en4), .win_len(wl4),
    .spike_in(sp4), .rate_ready(rdy4),
    .rate_data(data4), .rate_sat(sat4),
    .rate_valid(valid4), .overrun(ovr4),
    .overrun_clr(clr4), .busy(busy4)
  );

  // Reference: counts edges as an unbounded integer per window and
  // clips only when the window's result is reported.
  task automatic model_step();
    bit rise, acc, ld, st;
    if (rst) begin
      m_run = 0; m_left = 0; m_edges = 0; m_prev = 0;
      m_valid = 0; m_data = 0; m_sat = 0; m_ovr = 0;
      return;
    end
    rise = spike_in && !m_prev;
    acc  = m_valid && rate_ready;
    ld   = 0;
    st   = 0;
    if (m_run) begin
      m_edges += int'(rise);
      m_left--;
      if (m_left == 0) begin
        if (!m_valid || acc) begin
          ld     = 1;
          m_data = (m_edges > MAX) ? MAX : m_edges;
          m_sat  = (m_edges > MAX);
        end else begin
          st = 1;
        end
        if (en && win_len != 0) begin
          m_left  = int'(win_len);
          m_edges = 0;
        end else begin
          m_run = 0;
        end
      end else if (!en) begin
        m_run = 0;
      end
    end else if (en && win_len != 0) begin
      m_run   = 1;
      m_left  = int'(win_len);
      m_edges = 0;
    end
    if (ld)       m_valid = 1;
    else if (acc) m_valid = 0;
    if (st)               m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    m_prev = spike_in;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick(input bit r, input bit e, input int wl,
                      input bit s, input bit rd, input bit c);
    rst = r; en = e; win_len = 8'(wl);
    spike_in = s; rate_ready = rd; overrun_clr = c;
    @(posedge clk);
    model_step();
    #1;
    vectors++;
    if (rate_data !== 8'(m_data) || rate_sat !== m_sat ||
        rate_valid !== m_valid || overrun !== m_ovr ||
        busy !== m_run) begin
      miscompares++;
      $display("FAIL model t=%0t got/exp data=%0d/%0d sat=%0b/%0b valid=%0b/%0b ovr=%0b/%0b busy=%0b/%0b",
               $time, rate_data, m_data, rate_sat, m_sat,
               rate_valid, m_valid, overrun, m_ovr, busy, m_run);
    end
  endtask

  typedef struct {
    bit r, e;
    int wl;
    bit s, rd, c;
    bit xb, xv;
    int xd;
  } vec_t;

  vec_t tbl[15];

  initial begin
    rst4 = 1; en4 = 0; wl4 = 0; sp4 = 0; rdy4 = 1; clr4 = 0;

    tbl[0]  = '{1, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 1, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 10, 0, 1, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 10, 0, 1, 0, 1, 0, 0};
    tbl[4]  = '{0, 1, 10, 0, 1, 0, 1, 0, 0};
    tbl[5]  = '{0, 1, 10, 1, 1, 0, 1, 0, 0};
    tbl[6]  = '{0, 1, 10, 0, 1, 0, 1, 0, 0};
    tbl[7]  = '{0, 1, 10, 1, 1, 0, 1, 0, 0};
    tbl[8]  = '{0, 1, 10, 0, 1, 0, 1, 0, 0};
    tbl[9]  = '{0, 1, 10, 1, 1, 0, 1, 0, 0};
    tbl[10] = '{0, 1, 10, 0, 1, 0, 1, 0, 0};
    tbl[11] = '{0, 1, 10, 0, 1, 0, 1, 0, 0};
    tbl[12] = '{0, 1, 10, 0, 1, 0, 1, 0, 0};
    tbl[13] = '{0, 1, 10, 0, 1, 0, 1, 1, 3};
    tbl[14] = '{0, 1, 10, 0, 1, 0, 1, 0, 3};

    for (int i = 0; i < 15; i++) begin
      tick(tbl[i].r, tbl[i].e, tbl[i].wl, tbl[i].s, tbl[i].rd, tbl[i].c);
      chk($sformatf("tbl%0d busy", i), 32'(busy), 32'(tbl[i].xb));
      chk($sformatf("tbl%0d valid", i), 32'(rate_valid), 32'(tbl[i].xv));
      chk($sformatf("tbl%0d data", i), 32'(rate_data), 32'(tbl[i].xd));
    end
    tick(0, 0, 10, 0, 1, 0);
    chk("abort busy", 32'(busy), 0);

    // Level held high: one edge, none across the boundary.
    tick(0, 1, 8, 0, 1, 0);
    for (int k = 1; k <= 8; k++) tick(0, 1, 8, k >= 4, 1, 0);
    chk("hold w1 valid", 32'(rate_valid), 1);
    chk("hold w1 data", 32'(rate_data), 1);
    for (int k = 1; k <= 8; k++) tick(0, k < 8, 8, 1, 1, 0);
    chk("hold w2 valid", 32'(rate_valid), 1);
    chk("hold w2 data", 32'(rate_data), 0);
    chk("hold w2 busy", 32'(busy), 0);
    tick(0, 0, 0, 0, 1, 0);

    // Backpressure: second window is dropped.
    tick(0, 1, 12, 0, 0, 0);
    for (int k = 1; k <= 12; k++) tick(0, 1, 12, k == 2 || k == 5, 0, 0);
    chk("bp w1 valid", 32'(rate_valid), 1);
    chk("bp w1 data", 32'(rate_data), 2);
    chk("bp w1 ovr", 32'(overrun), 0);
    for (int k = 1; k <= 12; k++) tick(0, k < 12, 12, k % 2 == 1 && k <= 9, 0, 0);
    chk("bp w2 data", 32'(rate_data), 2);
    chk("bp w2 ovr", 32'(overrun), 1);
    tick(0, 0, 0, 0, 1, 0);
    chk("bp accept valid", 32'(rate_valid), 0);
    chk("bp ovr sticky", 32'(overrun), 1);
    tick(0, 0, 0, 0, 1, 1);
    chk("bp ovr clr", 32'(overrun), 0);

    // Early en drop, then reset mid-run.
    tick(0, 1, 10, 0, 1, 0);
    for (int k = 1; k <= 3; k++) tick(0, 1, 10, k == 2, 1, 0);
    tick(0, 0, 10, 0, 1, 0);
    chk("drop busy", 32'(busy), 0);
    for (int k = 0; k < 12; k++) tick(0, 0, 10, 0, 1, 0);
    chk("drop no valid", 32'(rate_valid), 0);
    tick(0, 1, 10, 0, 1, 0);
    for (int k = 1; k <= 3; k++) tick(0, 1, 10, k == 1, 1, 0);
    tick(1, 1, 10, 1, 1, 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst valid", 32'(rate_valid), 0);
    chk("rst data", 32'(rate_data), 0);

    // 4-bit counter: 20 edges clip to 15, then 14 edges fit.
    rst4 = 0; en4 = 1; wl4 = 40; sp4 = 0;
    tick(0, 0, 0, 0, 1, 0);
    wl4 = 28;
    for (int k = 1; k <= 40; k++) begin
      sp4 = (k % 2 == 1);
      tick(0, 0, 0, 0, 1, 0);
    end
    chk("sat4 valid", 32'(valid4), 1);
    chk("sat4 data", 32'(data4), 15);
    chk("sat4 flag", 32'(sat4), 1);
    for (int k = 1; k <= 28; k++) begin
      sp4 = (k % 2 == 1);
      en4 = (k < 28);
      tick(0, 0, 0, 0, 1, 0);
    end
    chk("nosat4 data", 32'(data4), 14);
    chk("nosat4 flag", 32'(sat4), 0);
    chk("nosat4 valid", 32'(valid4), 1);
    chk("nosat4 ovr", 32'(ovr4), 0);

    for (int n = 0; n < 4000; n++) begin
      tick($urandom % 200 == 0, $urandom % 16 != 0,
           $urandom_range(0, 14), $urandom % 3 == 0,
           $urandom % 4 != 0, $urandom % 8 == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
